// File: rtl/sprite_plotter.sv
// sprite_plotter: rectangle rasteriser feeding the VGA adapter pixel-write port.
// Latches a press/garbage/clear command on start, then emits one pixel per clock.
module sprite_plotter #(
  parameter int unsigned X_W        = 8,
  parameter int unsigned Y_W        = 7,
  parameter int unsigned SLOTS      = 4,
  parameter int unsigned P_W        = (SLOTS > 2) ? $clog2(SLOTS) : 1,
  parameter int unsigned SLOT_PITCH = 40,
  parameter int unsigned PRESS_W    = 40,
  parameter int unsigned PRESS_H    = 60,
  parameter int unsigned PRESS_X0   = 0,
  parameter int unsigned PRESS_Y0   = 0,
  parameter int unsigned GARB_W     = 20,
  parameter int unsigned GARB_H     = 20,
  parameter int unsigned GARB_X0    = 10,
  parameter int unsigned GARB_Y0    = 100,
  parameter int unsigned SCREEN_W   = 160,
  parameter int unsigned SCREEN_H   = 120,
  parameter logic [2:0]  FG         = 3'b111,
  parameter logic [2:0]  BG         = 3'b000
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           start,
  input  logic           item,
  input  logic           erase,
  input  logic           clear,
  input  logic [P_W-1:0] position,
  output logic           busy,
  output logic           done,
  output logic [X_W-1:0] x_cord,
  output logic [Y_W-1:0] y_cord,
  output logic [2:0]     colour_out,
  output logic           plot
);

  localparam int unsigned MAX_W0 = (PRESS_W > GARB_W) ? PRESS_W : GARB_W;
  localparam int unsigned MAX_W  = (SCREEN_W > MAX_W0) ? SCREEN_W : MAX_W0;
  localparam int unsigned MAX_H0 = (PRESS_H > GARB_H) ? PRESS_H : GARB_H;
  localparam int unsigned MAX_H  = (SCREEN_H > MAX_H0) ? SCREEN_H : MAX_H0;
  localparam int unsigned CW     = (MAX_W > 1) ? $clog2(MAX_W) : 1;
  localparam int unsigned CH     = (MAX_H > 1) ? $clog2(MAX_H) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] DRAW = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]     state_q, state_d;
  logic [CW-1:0]  xc_q, xc_d, wm1_q, wm1_d;
  logic [CH-1:0]  yc_q, yc_d, hm1_q, hm1_d;
  logic [X_W-1:0] ox_q, ox_d, x_cord_q, x_cord_d;
  logic [Y_W-1:0] oy_q, oy_d, y_cord_q, y_cord_d;
  logic [2:0]     col_q, col_d, colour_q, colour_d;
  logic           plot_q, plot_d, done_q, done_d, busy_q, busy_d;
  logic [X_W-1:0] slot_off;
  logic           pos_bad;

  assign slot_off = X_W'(X_W'(position) * X_W'(SLOT_PITCH));
  assign pos_bad  = 32'(position) >= SLOTS;

  // Next-state, command latching, counter stepping and pixel outputs
  always_comb begin
    state_d  = state_q;
    xc_d     = xc_q;
    yc_d     = yc_q;
    wm1_d    = wm1_q;
    hm1_d    = hm1_q;
    ox_d     = ox_q;
    oy_d     = oy_q;
    col_d    = col_q;
    x_cord_d = x_cord_q;
    y_cord_d = y_cord_q;
    colour_d = colour_q;
    plot_d   = 1'b0;
    done_d   = 1'b0;
    busy_d   = (state_q != IDLE);
    case (state_q)
      IDLE: begin
        if (start) begin
          xc_d = '0;
          yc_d = '0;
          if (clear) begin
            ox_d    = '0;
            oy_d    = '0;
            wm1_d   = CW'(SCREEN_W - 1);
            hm1_d   = CH'(SCREEN_H - 1);
            col_d   = BG;
            state_d = DRAW;
          end else begin
            if (item) begin
              ox_d  = X_W'(PRESS_X0) + slot_off;
              oy_d  = Y_W'(PRESS_Y0);
              wm1_d = CW'(PRESS_W - 1);
              hm1_d = CH'(PRESS_H - 1);
            end else begin
              ox_d  = X_W'(GARB_X0) + slot_off;
              oy_d  = Y_W'(GARB_Y0);
              wm1_d = CW'(GARB_W - 1);
              hm1_d = CH'(GARB_H - 1);
            end
            col_d   = erase ? BG : FG;
            // A slot index beyond the configured slots draws nothing
            state_d = pos_bad ? DONE : DRAW;
          end
        end
      end
      DRAW: begin
        x_cord_d = ox_q + X_W'(xc_q);
        y_cord_d = oy_q + Y_W'(yc_q);
        colour_d = col_q;
        plot_d   = 1'b1;
        if (xc_q < wm1_q) begin
          xc_d = xc_q + CW'(1);
        end else if (yc_q < hm1_q) begin
          xc_d = '0;
          yc_d = yc_q + CH'(1);
        end else begin
          xc_d    = '0;
          yc_d    = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, command and output registers with asynchronous clear
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      xc_q     <= '0;
      yc_q     <= '0;
      wm1_q    <= '0;
      hm1_q    <= '0;
      ox_q     <= '0;
      oy_q     <= '0;
      col_q    <= '0;
      x_cord_q <= '0;
      y_cord_q <= '0;
      colour_q <= '0;
      plot_q   <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      xc_q     <= xc_d;
      yc_q     <= yc_d;
      wm1_q    <= wm1_d;
      hm1_q    <= hm1_d;
      ox_q     <= ox_d;
      oy_q     <= oy_d;
      col_q    <= col_d;
      x_cord_q <= x_cord_d;
      y_cord_q <= y_cord_d;
      colour_q <= colour_d;
      plot_q   <= plot_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
    end
  end

  assign x_cord     = x_cord_q;
  assign y_cord     = y_cord_q;
  assign colour_out = colour_q;
  assign plot       = plot_q;
  assign done       = done_q;
  assign busy       = busy_q;

endmodule

// File: doc/sprite_plotter.md
# sprite_plotter

Parametrised rectangle rasteriser that drives the VGA adapter's pixel-write port. On a `start` pulse it latches a draw command: press sprite, garbage sprite or full-screen clear, plus slot position and draw/erase. It then emits one pixel per clock with `plot` high and reports completion with a one-cycle `done`. It sits between the game-control FSM and the VGA adapter, and supersedes the fixed 4-slot single-shot drawer.

## Interface
- `X_W`, 8: x coordinate width.
- `Y_W`, 7: y coordinate width.
- `SLOTS`, 4: number of slot positions; `P_W = max(1, $clog2(SLOTS))`.
- `SLOT_PITCH`, 40: x distance between adjacent slots.
- `PRESS_W` / `PRESS_H`, 40 / 60: press sprite size.
- `PRESS_X0` / `PRESS_Y0`, 0 / 0: press slot-0 origin.
- `GARB_W` / `GARB_H`, 20 / 20: garbage sprite size.
- `GARB_X0` / `GARB_Y0`, 10 / 100: garbage slot-0 origin.
- `SCREEN_W` / `SCREEN_H`, 160 / 120: area covered by a clear.
- `FG`, 3'b111: draw colour. `BG`, 3'b000: erase/clear colour.
- `clk` in 1: CLOCK_50.
- `reset_n` in 1: reset, asynchronous, active-low.
- `start` in 1: command strobe, sampled only in IDLE.
- `item` in 1: 1 = press, 0 = garbage.
- `erase` in 1: 1 = paint BG, 0 = paint FG.
- `clear` in 1: 1 = full-screen BG clear; overrides `item`, `erase` and `position`.
- `position` in P_W: slot index.
- `busy` out 1: command in progress.
- `done` out 1: one-cycle completion pulse.
- `x_cord` out X_W: pixel x.
- `y_cord` out Y_W: pixel y.
- `colour_out` out 3: pixel colour.
- `plot` out 1: VGA write enable.

## Operation
- FSM states are IDLE, DRAW and DONE. Reset state is IDLE.
- On reset, all outputs are 0 and the x/y counters are 0.
- **IDLE, `start`=1:** latch the command and compute the rectangle.
  - Press: origin (PRESS_X0 + position·SLOT_PITCH, PRESS_Y0), size PRESS_W×PRESS_H.
  - Garbage: origin (GARB_X0 + position·SLOT_PITCH, GARB_Y0), size GARB_W×GARB_H.
  - Clear: origin (0,0), size SCREEN_W×SCREEN_H, colour BG.
  - Next state is DRAW.
- **Out-of-range position:** if `position >= SLOTS` and `clear`=0, go directly to DONE. No pixel is plotted.
- **DRAW, each cycle:** register `x_cord = ox + xc`, `y_cord = oy + yc`, the latched colour, and `plot`=1.
  - If xc < W-1: increment xc.
  - Else if yc < H-1: set xc=0 and increment yc.
  - Else (xc = W-1, yc = H-1): clear both counters and go to DONE.
- **DONE:** `done`=1, `plot`=0, then go to IDLE.
- **`busy`:** high in DRAW and DONE.
- **`start` outside IDLE:** ignored, and not queued.
- **Input changes mid-command:** changes on `item`, `erase`, `clear` or `position` after `start` have no effect, because they are latched.
- **Arithmetic:** coordinate sums are computed at X_W/Y_W width; overflow wraps (truncates). The counters are sized for `max(SCREEN_W, PRESS_W, GARB_W)` and the equivalent height maximum. Keeping sprites on screen is the integrator's responsibility.
- **Reset mid-DRAW:** asynchronous return to IDLE with all outputs 0. No `done` pulse is produced.

## Timing
- `start` is sampled at edge T in IDLE.
- The first pixel (`plot`=1) is valid in the cycle after edge T+1.
- The last of the W·H pixels is valid after edge T+W·H.
- `done` and the final `busy` cycle occur after edge T+W·H+1.
- The next `start` is accepted at edge T+W·H+2 at the earliest.
- `plot` is high for exactly W·H consecutive cycles, with no gaps. Pixel order is row-major, x fastest.
- Out-of-range command: `done` occurs after edge T+1, with zero `plot` cycles.

## Test plan
- **Press, slot 2, draw:** `start`, `item`=1, `erase`=0, `position`=2 -> 2400 `plot` cycles; first pixel (80,0), last pixel (119,59), all `colour_out`=111; `done` one cycle later.
- **Garbage, slot 3, erase:** `item`=0, `erase`=1, `position`=3 -> 400 pixels from (130,100) to (149,119), `colour_out`=000, row wrap (149,100) -> (130,101).
- **Clear:** `clear`=1, `position`=3, `item`=1 -> 19200 pixels from (0,0) to (159,119), all 000; `position` and `item` are ignored.
- **`start` while busy:** second `start` pulse mid-press, plus `position` changed to 0 -> no restart, all pixels stay at slot 2, exactly one `done`.
- **Reset mid-DRAW:** assert `reset_n`=0 at pixel 100 of a press -> `plot`, `busy`, `x_cord`, `y_cord` go to 0 immediately and no `done`; a fresh `start` then draws all 2400 pixels.
- **SLOTS=3, `position`=3:** -> no `plot` cycle, `busy` high 1 cycle, `done` after edge T+1.
